// File: rtl/uart_host_port_pkg.sv
// uart_host_port_pkg
//   Shared types and constants for the UART host-side bus master.
//   - host_state_e : access sequencer states
//   - host_req_s   : request captured at the accept handshake
//   - IDLE_BUS_VALUE : value presented on data/response buses when idle
//   - max3         : elaboration helper used to size the sequencer counter
package uart_host_port_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_WAIT_RD = 3'd3,
    ST_HOLD_WR = 3'd4,
    ST_RESP    = 3'd5,
    ST_RECOVER = 3'd6
  } host_state_e;

  typedef struct packed {
    logic       write;
    logic [2:0] address;
    logic [7:0] data;
  } host_req_s;

  localparam logic [7:0] IDLE_BUS_VALUE = 8'h00;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/uart_host_port_sync_2ff.sv
// sync_2ff
//   One-bit two-flop synchroniser with synchronous active-low reset.
//   Both flops reset to 0; output follows d_i with two cycles of latency.
// Ports:
//   clk_i   : destination clock
//   rst_n_i : synchronous active-low reset
//   d_i     : asynchronous input
//   q_o     : synchronised output
module sync_2ff (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d_i;
      r_sync <= r_meta;
    end
  end

  assign q_o = r_sync;

endmodule

// File: rtl/uart_host_port.sv
// uart_host_port
//   Host-side bus master for the UART register bus. Accepts one request at a
//   time on a valid/ready interface, runs SETUP -> STROBE -> HOLD_WR/WAIT_RD
//   -> RESP -> RECOVER on the 3-bit address / read / write / 8-bit data bus,
//   owns the data-bus drive enable, and synchronises the UART irq_n line.
// Ports:
//   clk_i, rst_n_i                 : clock, synchronous active-low reset
//   req_valid_i / req_ready_o      : request handshake
//   req_write_i, req_address_i, req_data_i : request payload
//   rsp_valid_o / rsp_ready_i      : response handshake (held until ready)
//   rsp_data_o, rsp_write_o        : read data (0x00 on writes), type echo
//   address_o, read_o, write_o     : UART register bus controls
//   data_o, data_oe_o, data_i      : bus write data, drive enable, read data
//   irq_n_i, irq_pending_o         : raw UART interrupt, synchronised level
module uart_host_port
  import uart_host_port_pkg::*;
#(
  parameter int STROBE_CYCLES   = 2,
  parameter int READ_LATENCY    = 2,
  parameter int RECOVERY_CYCLES = 1
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_write_i,
  input  logic [2:0] req_address_i,
  input  logic [7:0] req_data_i,
  output logic       rsp_valid_o,
  input  logic       rsp_ready_i,
  output logic [7:0] rsp_data_o,
  output logic       rsp_write_o,
  output logic [2:0] address_o,
  output logic       read_o,
  output logic       write_o,
  output logic [7:0] data_o,
  output logic       data_oe_o,
  input  logic [7:0] data_i,
  input  logic       irq_n_i,
  output logic       irq_pending_o
);

  localparam int MAX_CYC = max3(STROBE_CYCLES, READ_LATENCY, RECOVERY_CYCLES);
  localparam int CW      = $clog2(MAX_CYC) + 1;

  if (STROBE_CYCLES < 1 || READ_LATENCY < 1 || RECOVERY_CYCLES < 1) begin : g_param_check
    $error("uart_host_port: STROBE_CYCLES, READ_LATENCY and RECOVERY_CYCLES must all be >= 1");
  end

  host_state_e   r_state;
  host_state_e   w_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_load;
  host_req_s     r_req;
  logic [7:0]    r_rsp_data;
  logic          r_req_ready;
  logic          w_accept;
  logic          w_cnt_done;
  logic          w_irq_active;

  assign w_accept   = (r_state == ST_IDLE) && r_req_ready && req_valid_i;
  assign w_cnt_done = (r_cnt == '0);

  // Next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_accept) w_next = ST_SETUP;
      ST_SETUP:   w_next = ST_STROBE;
      ST_STROBE:  if (w_cnt_done) w_next = r_req.write ? ST_HOLD_WR : ST_WAIT_RD;
      ST_HOLD_WR: w_next = ST_RESP;
      ST_WAIT_RD: if (w_cnt_done) w_next = ST_RESP;
      ST_RESP:    if (rsp_ready_i) w_next = ST_RECOVER;
      ST_RECOVER: if (w_cnt_done) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Counter holds remaining cycles minus one for the state being entered.
  always_comb begin
    w_load = '0;
    case (w_next)
      ST_STROBE:  w_load = CW'(STROBE_CYCLES - 1);
      ST_WAIT_RD: w_load = CW'(READ_LATENCY - 1);
      ST_RECOVER: w_load = CW'(RECOVERY_CYCLES - 1);
      default:    w_load = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_req       <= '0;
      r_rsp_data  <= IDLE_BUS_VALUE;
      r_req_ready <= 1'b0;
    end else begin
      r_state <= w_next;
      // Registered so ready stays low in the cycle that follows a reset edge
      // and rises in the first cycle spent in IDLE.
      r_req_ready <= (w_next == ST_IDLE);

      if (w_next != r_state) begin
        r_cnt <= w_load;
      end else if (!w_cnt_done) begin
        r_cnt <= r_cnt - CW'(1);
      end

      if (w_accept) begin
        r_req.write   <= req_write_i;
        r_req.address <= req_address_i;
        r_req.data    <= req_data_i;
        r_rsp_data    <= IDLE_BUS_VALUE;
      end

      if (r_state == ST_WAIT_RD && w_cnt_done) begin
        r_rsp_data <= data_i;
      end
    end
  end

  // Bus outputs decoded from registered state only: no input-to-output paths.
  always_comb begin
    address_o = '0;
    read_o    = 1'b0;
    write_o   = 1'b0;
    data_o    = IDLE_BUS_VALUE;
    data_oe_o = 1'b0;
    case (r_state)
      ST_SETUP, ST_STROBE, ST_HOLD_WR: begin
        address_o = r_req.address;
        if (r_req.write) begin
          data_o    = r_req.data;
          data_oe_o = 1'b1;
        end
        if (r_state == ST_STROBE) begin
          read_o  = ~r_req.write;
          write_o = r_req.write;
        end
      end
      ST_WAIT_RD: address_o = r_req.address;
      default: ;
    endcase
  end

  assign req_ready_o = r_req_ready;
  assign rsp_valid_o = (r_state == ST_RESP);
  assign rsp_write_o = (r_state == ST_RESP) && r_req.write;
  assign rsp_data_o  = (r_state == ST_RESP) ? r_rsp_data : IDLE_BUS_VALUE;

  assign w_irq_active = ~irq_n_i;

  sync_2ff u_irq_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (w_irq_active),
    .q_o     (irq_pending_o)
  );

endmodule

// File: tb/tb_uart_host_port.sv
module tb_uart_host_port;

  logic       clk = 1'b0;
  logic       rst_n_i;
  logic       req_valid_i;
  logic       req_ready_o;
  logic       req_write_i;
  logic [2:0] req_address_i;
  logic [7:0] req_data_i;
  logic       rsp_valid_o;
  logic       rsp_ready_i;
  logic [7:0] rsp_data_o;
  logic       rsp_write_o;
  logic [2:0] address_o;
  logic       read_o;
  logic       write_o;
  logic [7:0] data_o;
  logic       data_oe_o;
  logic [7:0] data_i;
  logic       irq_n_i;
  logic       irq_pending_o;

  always #5 clk = ~clk;

  uart_host_port #(
    .STROBE_CYCLES   (2),
    .READ_LATENCY    (2),
    .RECOVERY_CYCLES (1)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_write_i   (req_write_i),
    .req_address_i (req_address_i),
    .req_data_i    (req_data_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_data_o    (rsp_data_o),
    .rsp_write_o   (rsp_write_o),
    .address_o     (address_o),
    .read_o        (read_o),
    .write_o       (write_o),
    .data_o        (data_o),
    .data_oe_o     (data_oe_o),
    .data_i        (data_i),
    .irq_n_i       (irq_n_i),
    .irq_pending_o (irq_pending_o)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int inv_viol = 0;
  logic [8:0] exp_q[$];   // {write, data}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    $display("FAIL %s: wait expired, required event did not occur", name);
  endtask

  task automatic wait_ready(input string name);
    int k;
    k = 0;
    while (!req_ready_o && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready_o) timeout_fail(name);
  endtask

  // UART register model: captures writes on write_o rising, drives data_i
  // with the addressed register only during the read-latency window.
  logic [7:0] mem [8] = '{8'h00, 8'h00, 8'h5A, 8'h00, 8'h00, 8'h3C, 8'h00, 8'h00};
  logic prev_rd = 1'b0;
  logic prev_wr = 1'b0;
  int   rd_win  = 0;

  always @(negedge clk) begin
    if (write_o && !prev_wr) mem[address_o] = data_o;
    prev_wr = write_o;
    if (read_o) prev_rd = 1'b1;
    else if (prev_rd) begin
      prev_rd = 1'b0;
      rd_win  = 2;
    end
    if (rd_win > 0) begin
      data_i = mem[address_o];
      rd_win--;
    end else begin
      data_i = 8'hEE;
    end
  end

  always @(negedge clk) begin
    if (rst_n_i === 1'b1 && ((read_o && write_o) || (read_o && data_oe_o))) inv_viol++;
  end

  // Scoreboard monitor: compares each response at its handshake.
  always @(negedge clk) begin
    logic [8:0] e;
    #2;
    if (rst_n_i === 1'b1 && rsp_valid_o && rsp_ready_i) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_rsp: got data=%02h write=%0b, required no response", rsp_data_o, rsp_write_o);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_data", {24'h0, rsp_data_o}, {24'h0, e[7:0]});
        chk("rsp_write", {31'h0, rsp_write_o}, {31'h0, e[8]});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required completion before time limit");
    $fatal(1);
  end

  initial begin
    int k, cyc, v, r;
    logic saw;
    rst_n_i = 1'b0; req_valid_i = 1'b0; req_write_i = 1'b0;
    req_address_i = '0; req_data_i = '0; rsp_ready_i = 1'b1; irq_n_i = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'h0, req_ready_o}, 0);
    chk("rst_rsp_valid", {31'h0, rsp_valid_o}, 0);
    chk("rst_strobes",   {30'h0, read_o, write_o}, 0);
    chk("rst_data_oe",   {31'h0, data_oe_o}, 0);
    chk("rst_address",   {29'h0, address_o}, 0);
    chk("rst_data_o",    {24'h0, data_o}, 0);
    chk("rst_rsp_data",  {24'h0, rsp_data_o}, 0);
    chk("rst_irq",       {31'h0, irq_pending_o}, 0);
    rst_n_i = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'h0, req_ready_o}, 1);

    // Write addr=3 data=0xA5
    wait_ready("wr_ready");
    req_valid_i = 1'b1; req_write_i = 1'b1; req_address_i = 3'd3; req_data_i = 8'hA5;
    exp_q.push_back({1'b1, 8'h00});
    for (int t = 1; t <= 7; t++) begin
      @(negedge clk);
      if (t == 1) req_valid_i = 1'b0;
      if (t <= 4) begin
        chk($sformatf("wr_t%0d_addr", t), {29'h0, address_o}, 3);
        chk($sformatf("wr_t%0d_data", t), {24'h0, data_o}, 32'hA5);
      end
      if (t <= 5) begin
        chk($sformatf("wr_t%0d_write", t), {31'h0, write_o}, (t == 2 || t == 3) ? 1 : 0);
        chk($sformatf("wr_t%0d_read", t), {31'h0, read_o}, 0);
        chk($sformatf("wr_t%0d_oe", t), {31'h0, data_oe_o}, (t <= 4) ? 1 : 0);
        chk($sformatf("wr_t%0d_rsp_valid", t), {31'h0, rsp_valid_o}, (t == 5) ? 1 : 0);
      end
      if (t == 6) chk("wr_t6_rsp_valid", {31'h0, rsp_valid_o}, 0);
      if (t == 7) chk("wr_t7_ready", {31'h0, req_ready_o}, 1);
    end

    // Read addr=5, model returns 0x3C
    wait_ready("rd_ready");
    req_valid_i = 1'b1; req_write_i = 1'b0; req_address_i = 3'd5; req_data_i = 8'hFF;
    exp_q.push_back({1'b0, 8'h3C});
    for (int t = 1; t <= 8; t++) begin
      @(negedge clk);
      if (t == 1) req_valid_i = 1'b0;
      if (t <= 5) chk($sformatf("rd_t%0d_addr", t), {29'h0, address_o}, 5);
      if (t <= 6) begin
        chk($sformatf("rd_t%0d_read", t), {31'h0, read_o}, (t == 2 || t == 3) ? 1 : 0);
        chk($sformatf("rd_t%0d_write", t), {31'h0, write_o}, 0);
        chk($sformatf("rd_t%0d_oe", t), {31'h0, data_oe_o}, 0);
        chk($sformatf("rd_t%0d_rsp_valid", t), {31'h0, rsp_valid_o}, (t == 6) ? 1 : 0);
      end
      if (t == 7) chk("rd_t7_rsp_valid", {31'h0, rsp_valid_o}, 0);
      if (t == 8) chk("rd_t8_ready", {31'h0, req_ready_o}, 1);
    end

    // Backpressure on read addr=2 (0x5A), second request (write 1/0x77) pending
    wait_ready("bp_ready");
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b1; req_write_i = 1'b0; req_address_i = 3'd2; req_data_i = 8'h00;
    exp_q.push_back({1'b0, 8'h5A});
    @(negedge clk);
    req_write_i = 1'b1; req_address_i = 3'd1; req_data_i = 8'h77;
    exp_q.push_back({1'b1, 8'h00});
    k = 0;
    while (!rsp_valid_o && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!rsp_valid_o) timeout_fail("bp_rsp_valid");
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp_c%0d_valid", i), {31'h0, rsp_valid_o}, 1);
      chk($sformatf("bp_c%0d_data", i), {24'h0, rsp_data_o}, 32'h5A);
      chk($sformatf("bp_c%0d_ready", i), {31'h0, req_ready_o}, 0);
      @(negedge clk);
    end
    rsp_ready_i = 1'b1;
    @(negedge clk);
    chk("bp_h1_ready", {31'h0, req_ready_o}, 0);
    chk("bp_h1_valid", {31'h0, rsp_valid_o}, 0);
    @(negedge clk);
    chk("bp_h2_ready", {31'h0, req_ready_o}, 1);
    @(negedge clk);
    chk("bp_h3_accepted", {31'h0, req_ready_o}, 0);
    req_valid_i = 1'b0;
    wait_ready("bp_done");

    // Back-to-back write 6/0xC3 then read 6, req_valid_i held high
    req_valid_i = 1'b1; req_write_i = 1'b1; req_address_i = 3'd6; req_data_i = 8'hC3;
    exp_q.push_back({1'b1, 8'h00});
    @(negedge clk);
    req_write_i = 1'b0; req_data_i = 8'h00;
    exp_q.push_back({1'b0, 8'hC3});
    cyc = 1; v = -1; r = -1;
    while (r < 0 && cyc < 40) begin
      if (v < 0 && rsp_valid_o) v = cyc;
      if (v >= 0 && req_ready_o) r = cyc;
      if (r < 0) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (r < 0) timeout_fail("b2b_second_accept");
    else chk("b2b_gap", r - v, 2);
    @(negedge clk);
    req_valid_i = 1'b0;
    chk("b2b_accepted", {31'h0, req_ready_o}, 0);
    wait_ready("b2b_done");

    // Reset during the strobe of a write
    req_valid_i = 1'b1; req_write_i = 1'b1; req_address_i = 3'd4; req_data_i = 8'h11;
    k = 0;
    do begin
      @(negedge clk);
      req_valid_i = 1'b0;
      k++;
    end while (!write_o && k < 10);
    if (!write_o) timeout_fail("mr_strobe");
    rst_n_i = 1'b0;
    @(negedge clk);
    chk("mr_write",     {31'h0, write_o}, 0);
    chk("mr_oe",        {31'h0, data_oe_o}, 0);
    chk("mr_rsp_valid", {31'h0, rsp_valid_o}, 0);
    chk("mr_ready",     {31'h0, req_ready_o}, 0);
    chk("mr_address",   {29'h0, address_o}, 0);
    rst_n_i = 1'b1;
    @(negedge clk);
    chk("mr_ready_after", {31'h0, req_ready_o}, 1);
    saw = 1'b0;
    repeat (10) begin
      @(negedge clk);
      saw = saw | rsp_valid_o;
    end
    chk("mr_no_response", {31'h0, saw}, 0);

    // IRQ synchroniser
    irq_n_i = 1'b0;
    @(negedge clk);
    chk("irq_c1", {31'h0, irq_pending_o}, 0);
    @(negedge clk);
    chk("irq_c2", {31'h0, irq_pending_o}, 1);
    irq_n_i = 1'b1;
    @(negedge clk);
    chk("irq_d1", {31'h0, irq_pending_o}, 1);
    @(negedge clk);
    chk("irq_d2", {31'h0, irq_pending_o}, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("bus_invariants", inv_viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_host_port.md
Name: uart_host_port

Overview:
- Host-side bus master sitting directly upstream of the UART top.
- Converts a valid/ready request/response byte interface into the UART 8-bit register bus: 3-bit address, read/write strobes, bidirectional data.
- Sequences setup, strobe, hold/turnaround and read-data capture. Owns the tristate enable for the data bus.
- Synchronises the UART's active-low interrupt line for the host.

Parameters:
STROBE_CYCLES, 2, cycles read_o/write_o held high per access (>=1; rising edge is what the UART detects)
READ_LATENCY, 2, cycles after strobe deassertion before data_i is sampled (>=1)
RECOVERY_CYCLES, 1, idle cycles with strobes low after each access before next request accepted (>=1)

Ports:
clk_i  in  1  clock
rst_n_i  in  1  synchronous active-low reset
req_valid_i  in  1  host request valid
req_ready_o  out  1  request accepted when valid&ready
req_write_i  in  1  1=write, 0=read
req_address_i  in  3  UART register address
req_data_i  in  8  write data
rsp_valid_o  out  1  response valid, held until rsp_ready_i
rsp_ready_i  in  1  host accepts response
rsp_data_o  out  8  read data (0x00 for writes)
rsp_write_o  out  1  echo of request type
address_o  out  3  to UART address_i
read_o  out  1  to UART read_i
write_o  out  1  to UART write_i
data_o  out  8  write data toward bus tristate (top level)
data_oe_o  out  1  drive enable for data bus; 0 = UART may drive
data_i  in  8  bus value sampled on reads
irq_n_i  in  1  UART irq_n_o, asynchronous to host logic
irq_pending_o  out  1  2-FF synchronised, inverted irq_n_i

Behaviour:
- Clock is clk_i; reset is synchronous and active-low on rst_n_i. All state updates on rising clk_i.
- Reset values:
  - FSM=IDLE, counter=0.
  - req_ready_o=0 during reset, 1 in the first IDLE cycle after release.
  - rsp_valid_o=0, rsp_data_o=0x00, rsp_write_o=0.
  - address_o=0, read_o=0, write_o=0, data_o=0x00, data_oe_o=0.
  - irq synchroniser flops=0 (irq_pending_o=0).
- FSM states: IDLE, SETUP, STROBE, WAIT_RD, HOLD_WR, RESP, RECOVER.
- IDLE:
  - req_ready_o=1; all other outputs are in their inactive state.
  - On req_valid_i&req_ready_o: latch address, write flag, data; go to SETUP.
- SETUP (1 cycle):
  - address_o driven.
  - Write: data_o driven and data_oe_o=1.
  - Strobes low. Go to STROBE.
- STROBE (STROBE_CYCLES cycles):
  - read_o or write_o=1; address and write data stable.
  - Exit to HOLD_WR (write) or WAIT_RD (read).
- HOLD_WR (1 cycle): write_o=0, data_oe_o still 1, address held. Go to RESP with data_oe_o=0.
- WAIT_RD (READ_LATENCY cycles):
  - read_o=0, data_oe_o=0, address held.
  - data_i registered into rsp_data_o on the last cycle. Go to RESP.
- RESP:
  - rsp_valid_o=1; rsp_data_o and rsp_write_o stable.
  - On rsp_ready_i, go to RECOVER. rsp_valid_o drops the next cycle.
- RECOVER (RECOVERY_CYCLES cycles): all bus outputs inactive. Go to IDLE.
- Invariants:
  - data_oe_o is never 1 in the same cycle as read_o, or in WAIT_RD.
  - read_o and write_o are never both 1.
- Latency from accept cycle T with defaults:
  - Write: strobe at T+2..T+3, rsp_valid_o first at T+5.
  - Read: strobe at T+2..T+3, data_i sampled at end of T+5, rsp_valid_o first at T+6.
  - Back-to-back with rsp_ready_i tied 1: next accept 2 cycles after rsp_valid_o.
- Only one outstanding request; req_ready_o=0 in every state except IDLE.
- Request inputs are ignored outside IDLE; latched values are not affected by later input changes.
- Reset asserted mid-access:
  - Next edge forces IDLE with all outputs at reset values; any strobe is truncated.
  - The response is discarded with no rsp_valid_o.
- Counter width is $clog2 of the largest parameter + 1. The counter reloads on every state entry.
- Parameter violations (value <1) are flagged by an elaboration-time assertion.
- irq_pending_o is 2-cycle latency from irq_n_i, with no further filtering.

Decomposition:
- Package uart_host_port_pkg:
  - state enum host_state_e.
  - request struct host_req_s (write, address[2:0], data[7:0]).
  - constant IDLE_BUS_VALUE=8'h00.
- Sub-module sync_2ff (1-bit two-flop synchroniser with synchronous active-low reset), used for irq_n_i.

Test Plan:
- Write addr=3, data=0xA5 with rsp_ready_i=1:
  - address_o=3 from T+1; write_o=1 exactly cycles T+2,T+3.
  - data_o=0xA5, data_oe_o=1 over T+1..T+4.
  - rsp_valid_o at T+5 with rsp_write_o=1, rsp_data_o=0x00.
- Read addr=5, bench drives data_i=0x3C only during WAIT_RD:
  - read_o=1 at T+2,T+3; data_oe_o=0 throughout.
  - rsp_data_o=0x3C, rsp_valid_o at T+6.
- Backpressure: rsp_ready_i=0 for 10 cycles on a read:
  - rsp_valid_o and rsp_data_o stable all 10 cycles; req_ready_o=0.
  - A second req_valid_i is not accepted until 2 cycles after the handshake.
- Back-to-back write then read with req_valid_i held 1 and inputs changed only on accept:
  - Both complete in order.
  - No cycle has read_o&write_o or read_o&data_oe_o.
- rst_n_i=0 for one cycle during STROBE of a write:
  - Next cycle write_o=0, data_oe_o=0, rsp_valid_o=0, req_ready_o=0.
  - After release, req_ready_o=1; no spurious response appears.
- irq_n_i 1->0 at cycle C: irq_pending_o=1 at C+2. irq_n_i 0->1: irq_pending_o=0 two cycles later.
